dmem_arbiter: RTL and testbench

- Shares the single-port data RAM between the pipeline MEM stage (the Ex/Mem access) and an external host/loader port, issuing at most one memory access per cycle.
- The pipeline has priority. The host is served in idle cycles, or by a forced, stalled grant once its wait limit is reached.
- Sits between the Ex/Mem register outputs and the data RAM port. It drives `Pipe_Stall` back to the hazard/pipeline-enable logic.

---
 rtl/dmem_arb_pkg.sv | 12 +
 rtl/dmem_wait_ctr.sv | 25 ++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared data-memory widths and arbiter state encoding
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 5;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    ARB = 1'b0,
    ACK = 1'b1
  } arbStateT;

endpackage

// File: rtl/dmem_wait_ctr.sv
// rtl/dmem_wait_ctr.sv - saturating host wait counter with clear and terminal flag
module dmem_wait_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rstN,
  input  logic inc,
  input  logic clr,
  output logic atMax
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstN || clr) begin
      cnt <= '0;
    end else if (inc && !atMax) begin
      cnt <= cnt + W'(1);
    end
  end

  assign atMax = (cnt == W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - pipeline/host arbiter for the single-port data RAM
// DMEM_ARB_STARVE_GUARD_EN adds the host wait counter and forced, stalled grant.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W        = DMEM_ADDR_W,
  parameter int DATA_W        = DMEM_DATA_W,
  parameter int HOST_WAIT_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              ExMem_MemRead,
  input  logic              ExMem_MemWrite,
  input  logic [ADDR_W-1:0] ExMem_AluOut,
  input  logic [DATA_W-1:0] ExMem_DataRt,
  input  logic              Host_Req,
  input  logic              Host_We,
  input  logic [ADDR_W-1:0] Host_Addr,
  input  logic [DATA_W-1:0] Host_WData,
  output logic              Host_Ack,
  output logic [DATA_W-1:0] Host_RData,
  output logic              Mem_Rd,
  output logic              Mem_Wr,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Pipe_Stall,
  output logic              Grant_Host
);

  arbStateT state, nextState;
  logic     pipeAcc;
  logic     forceGrant;
  logic     hostGrant;
  logic     pipeGrant;

  if (HOST_WAIT_MAX < 1) begin : gBadWaitMax
    $error("dmem_arbiter: HOST_WAIT_MAX must be at least 1");
  end

  assign pipeAcc = ExMem_MemRead | ExMem_MemWrite;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(HOST_WAIT_MAX + 1);

  logic waitInc;
  logic waitClr;

  assign waitInc = (state == ARB) && Host_Req && !hostGrant;
  assign waitClr = hostGrant || !Host_Req || (state == ACK);

  dmem_wait_ctr #(
    .MAX (HOST_WAIT_MAX),
    .W   (CNT_W)
  ) uWaitCtr (
    .clk   (CLK),
    .rstN  (RST_n),
    .inc   (waitInc),
    .clr   (waitClr),
    .atMax (forceGrant)
  );
`else
  assign forceGrant = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state <= ARB;
    end else begin
      state <= nextState;
    end
  end

  // ACK never grants the host, so one request cannot be issued twice.
  always_comb begin
    nextState  = ARB;
    hostGrant  = 1'b0;
    pipeGrant  = 1'b0;
    Pipe_Stall = 1'b0;
    unique case (state)
      ARB: begin
        if (forceGrant && Host_Req) begin
          hostGrant  = 1'b1;
          Pipe_Stall = 1'b1;
        end else if (pipeAcc) begin
          pipeGrant = 1'b1;
        end else if (Host_Req) begin
          hostGrant = 1'b1;
        end
      end
      ACK: begin
        pipeGrant = pipeAcc;
      end
      default: begin
        pipeGrant = 1'b0;
      end
    endcase
    if (hostGrant) begin
      nextState = ACK;
    end
    if (!RST_n) begin
      hostGrant  = 1'b0;
      pipeGrant  = 1'b0;
      Pipe_Stall = 1'b0;
    end
  end

  always_comb begin
    Mem_Rd    = 1'b0;
    Mem_Wr    = 1'b0;
    Mem_Addr  = '0;
    Mem_WData = '0;
    if (hostGrant) begin
      Mem_Rd    = !Host_We;
      Mem_Wr    = Host_We;
      Mem_Addr  = Host_Addr;
      Mem_WData = Host_WData;
    end else if (pipeGrant) begin
      // A simultaneous load and store resolves to the store.
      Mem_Rd    = ExMem_MemRead & ~ExMem_MemWrite;
      Mem_Wr    = ExMem_MemWrite;
      Mem_Addr  = ExMem_AluOut;
      Mem_WData = ExMem_DataRt;
    end
  end

  assign Grant_Host = hostGrant;
  assign Host_Ack   = (state == ACK) && RST_n;
  assign Host_RData = Host_Ack ? Mem_RData : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural RAM
module tb_dmem_arbiter;

  localparam int ADDR_W        = 5;
  localparam int DATA_W        = 32;
  localparam int HOST_WAIT_MAX = 4;

  logic              CLK = 1'b0;
  logic              RST_n = 1'b0;
  logic              ExMem_MemRead = 1'b0;
  logic              ExMem_MemWrite = 1'b0;
  logic [ADDR_W-1:0] ExMem_AluOut = '0;
  logic [DATA_W-1:0] ExMem_DataRt = '0;
  logic              Host_Req = 1'b0;
  logic              Host_We = 1'b0;
  logic [ADDR_W-1:0] Host_Addr = '0;
  logic [DATA_W-1:0] Host_WData = '0;
  logic              Host_Ack;
  logic [DATA_W-1:0] Host_RData;
  logic              Mem_Rd;
  logic              Mem_Wr;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_WData;
  logic [DATA_W-1:0] Mem_RData = '0;
  logic              Pipe_Stall;
  logic              Grant_Host;

  typedef struct packed {
    logic              isRead;
    logic [DATA_W-1:0] data;
  } hostExpT;

  hostExpT           hostQ[$];
  hostExpT           monExp;
  logic [DATA_W-1:0] ram [32] = '{default: '0};
  int                total = 0;
  int                bad = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .HOST_WAIT_MAX (HOST_WAIT_MAX)
  ) dut (
    .CLK            (CLK),
    .RST_n          (RST_n),
    .ExMem_MemRead  (ExMem_MemRead),
    .ExMem_MemWrite (ExMem_MemWrite),
    .ExMem_AluOut   (ExMem_AluOut),
    .ExMem_DataRt   (ExMem_DataRt),
    .Host_Req       (Host_Req),
    .Host_We        (Host_We),
    .Host_Addr      (Host_Addr),
    .Host_WData     (Host_WData),
    .Host_Ack       (Host_Ack),
    .Host_RData     (Host_RData),
    .Mem_Rd         (Mem_Rd),
    .Mem_Wr         (Mem_Wr),
    .Mem_Addr       (Mem_Addr),
    .Mem_WData      (Mem_WData),
    .Mem_RData      (Mem_RData),
    .Pipe_Stall     (Pipe_Stall),
    .Grant_Host     (Grant_Host)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge CLK) begin
    if (Mem_Wr) ram[Mem_Addr] <= Mem_WData;
    if (Mem_Rd) Mem_RData <= ram[Mem_Addr];
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (Host_Ack) begin
      if (hostQ.size() == 0) begin
        checkVal("ack_unexpected", 64'(Host_Ack), 64'd0);
      end else begin
        monExp = hostQ.pop_front();
        if (monExp.isRead) checkVal("host_rdata", 64'(Host_RData), 64'(monExp.data));
      end
    end else begin
      checkVal("rdata_idle", 64'(Host_RData), 64'd0);
    end
  end

  task automatic hostDo(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input logic [DATA_W-1:0] expRd, input int expWait, input logic expStall);
    int waited;
    bit granted;
    waited  = 0;
    granted = 1'b0;
    hostQ.push_back('{isRead: !we, data: expRd});
    Host_Req   = 1'b1;
    Host_We    = we;
    Host_Addr  = addr;
    Host_WData = wdata;
    while (!granted && waited <= 20) begin
      @(negedge CLK);
      if (Grant_Host) begin
        granted = 1'b1;
      end else begin
        checkVal("stall_while_wait", 64'(Pipe_Stall), 64'd0);
        waited++;
        nextCycle();
      end
    end
    checkVal("host_granted", 64'(granted), 64'd1);
    checkVal("host_wait", 64'(waited), 64'(expWait));
    if (granted) begin
      checkVal("grant_addr", 64'(Mem_Addr), 64'(addr));
      checkVal("grant_wr", 64'(Mem_Wr), 64'(we));
      checkVal("grant_rd", 64'(Mem_Rd), 64'(!we));
      if (we) checkVal("grant_wdata", 64'(Mem_WData), 64'(wdata));
      checkVal("grant_stall", 64'(Pipe_Stall), 64'(expStall));
      nextCycle();
      @(negedge CLK);
      checkVal("ack_pulse", 64'(Host_Ack), 64'd1);
      checkVal("ack_no_regrant", 64'(Grant_Host), 64'd0);
      checkVal("ack_no_stall", 64'(Pipe_Stall), 64'd0);
      checkVal("ack_pipe_wr", 64'(Mem_Wr), 64'(ExMem_MemWrite));
      checkVal("ack_pipe_rd", 64'(Mem_Rd), 64'(ExMem_MemRead & ~ExMem_MemWrite));
      checkVal("ack_pipe_addr", 64'(Mem_Addr),
               (ExMem_MemRead | ExMem_MemWrite) ? 64'(ExMem_AluOut) : 64'd0);
    end
    nextCycle();
    Host_Req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Host_Req = 1'b1; Host_We = 1'b1; Host_Addr = 5'd3; Host_WData = 32'hDEAD;
    ExMem_MemWrite = 1'b1; ExMem_AluOut = 5'd1; ExMem_DataRt = 32'hBEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checkVal("rst_mem_wr", 64'(Mem_Wr), 64'd0);
      checkVal("rst_ack", 64'(Host_Ack), 64'd0);
      checkVal("rst_stall", 64'(Pipe_Stall), 64'd0);
      checkVal("rst_grant", 64'(Grant_Host), 64'd0);
      nextCycle();
    end
    RST_n = 1'b1; Host_Req = 1'b0; ExMem_MemWrite = 1'b0; ExMem_AluOut = '0; ExMem_DataRt = '0;
    @(negedge CLK);
    checkVal("post_rst_ack", 64'(Host_Ack), 64'd0);
    checkVal("rst_no_ram_wr", 64'(ram[3] | ram[1]), 64'd0);
    nextCycle();

    ExMem_MemWrite = 1'b1; ExMem_AluOut = 5'd9; ExMem_DataRt = 32'd65;
    @(negedge CLK);
    checkVal("pst_wr", 64'(Mem_Wr), 64'd1);
    checkVal("pst_rd", 64'(Mem_Rd), 64'd0);
    checkVal("pst_addr", 64'(Mem_Addr), 64'd9);
    checkVal("pst_wdata", 64'(Mem_WData), 64'd65);
    checkVal("pst_grant_host", 64'(Grant_Host), 64'd0);
    checkVal("pst_stall", 64'(Pipe_Stall), 64'd0);
    nextCycle();

    ExMem_MemWrite = 1'b0; ExMem_MemRead = 1'b1;
    @(negedge CLK);
    checkVal("pld_rd", 64'(Mem_Rd), 64'd1);
    checkVal("pld_wr", 64'(Mem_Wr), 64'd0);
    checkVal("pld_addr", 64'(Mem_Addr), 64'd9);
    nextCycle();
    ExMem_MemRead = 1'b0;
    @(negedge CLK);
    checkVal("pld_rdata", 64'(Mem_RData), 64'd65);
    nextCycle();

    ExMem_MemRead = 1'b1; ExMem_MemWrite = 1'b1; ExMem_AluOut = 5'd7; ExMem_DataRt = 32'h55;
    @(negedge CLK);
    checkVal("both_wr", 64'(Mem_Wr), 64'd1);
    checkVal("both_rd", 64'(Mem_Rd), 64'd0);
    checkVal("both_addr", 64'(Mem_Addr), 64'd7);
    checkVal("both_wdata", 64'(Mem_WData), 64'h55);
    nextCycle();

    ExMem_MemRead = 1'b0; ExMem_MemWrite = 1'b0; ExMem_AluOut = 5'd5; ExMem_DataRt = 32'd123;
    @(negedge CLK);
    checkVal("idle_rd", 64'(Mem_Rd), 64'd0);
    checkVal("idle_wr", 64'(Mem_Wr), 64'd0);
    checkVal("idle_addr", 64'(Mem_Addr), 64'd0);
    checkVal("idle_wdata", 64'(Mem_WData), 64'd0);
    checkVal("idle_grant", 64'(Grant_Host), 64'd0);
    checkVal("both_ram", 64'(ram[7]), 64'h55);
    nextCycle();
    ExMem_AluOut = '0; ExMem_DataRt = '0;

    hostDo(1'b1, 5'd29, 32'd34, 32'd0, 0, 1'b0);
    hostDo(1'b1, 5'd25, 32'hA5, 32'd0, 0, 1'b0);
    hostDo(1'b0, 5'd29, 32'd0, 32'd34, 0, 1'b0);

    ExMem_MemRead = 1'b1; ExMem_AluOut = 5'd9;
    Host_Req = 1'b1; Host_We = 1'b0; Host_Addr = 5'd25;
    @(negedge CLK);
    checkVal("coll_addr", 64'(Mem_Addr), 64'd9);
    checkVal("coll_rd", 64'(Mem_Rd), 64'd1);
    checkVal("coll_grant_host", 64'(Grant_Host), 64'd0);
    nextCycle();
    ExMem_MemRead = 1'b0; ExMem_AluOut = '0;
    hostDo(1'b0, 5'd25, 32'd0, 32'hA5, 0, 1'b0);

    ExMem_MemWrite = 1'b1; ExMem_AluOut = 5'd10; ExMem_DataRt = 32'd77;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    hostDo(1'b0, 5'd29, 32'd0, 32'd34, HOST_WAIT_MAX, 1'b1);
`else
    Host_Req = 1'b1; Host_We = 1'b0; Host_Addr = 5'd29;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checkVal("nog_grant", 64'(Grant_Host), 64'd0);
      checkVal("nog_stall", 64'(Pipe_Stall), 64'd0);
      nextCycle();
    end
    ExMem_MemWrite = 1'b0;
    hostDo(1'b0, 5'd29, 32'd0, 32'd34, 0, 1'b0);
`endif
    ExMem_MemWrite = 1'b0;
    checkVal("starve_pipe_ram", 64'(ram[10]), 64'd77);

    ExMem_MemWrite = 1'b1; ExMem_AluOut = 5'd11; ExMem_DataRt = 32'd5;
    Host_Req = 1'b1; Host_We = 1'b0; Host_Addr = 5'd25;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkVal("drop_wait_grant", 64'(Grant_Host), 64'd0);
      nextCycle();
    end
    Host_Req = 1'b0; ExMem_MemWrite = 1'b0;
    @(negedge CLK);
    checkVal("drop_no_grant", 64'(Grant_Host), 64'd0);
    checkVal("drop_no_rd", 64'(Mem_Rd), 64'd0);
    checkVal("drop_no_wr", 64'(Mem_Wr), 64'd0);
    nextCycle();
    ExMem_MemWrite = 1'b1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    hostDo(1'b0, 5'd25, 32'd0, 32'hA5, HOST_WAIT_MAX, 1'b1);
`else
    ExMem_MemWrite = 1'b0;
    hostDo(1'b0, 5'd25, 32'd0, 32'hA5, 0, 1'b0);
`endif
    ExMem_MemWrite = 1'b0; ExMem_AluOut = '0; ExMem_DataRt = '0;

    Host_Req = 1'b1; Host_We = 1'b1; Host_Addr = 5'd12; Host_WData = 32'h99;
    @(negedge CLK);
    checkVal("rack_grant", 64'(Grant_Host), 64'd1);
    checkVal("rack_wr", 64'(Mem_Wr), 64'd1);
    nextCycle();
    RST_n = 1'b0; Host_Req = 1'b0;
    @(negedge CLK);
    checkVal("rack_ack_lost", 64'(Host_Ack), 64'd0);
    checkVal("rack_grant_rst", 64'(Grant_Host), 64'd0);
    checkVal("rack_wr_rst", 64'(Mem_Wr), 64'd0);
    checkVal("rack_ram", 64'(ram[12]), 64'h99);
    nextCycle();
    RST_n = 1'b1;
    @(negedge CLK);
    checkVal("rack_post_ack", 64'(Host_Ack), 64'd0);
    nextCycle();
    hostDo(1'b0, 5'd12, 32'd0, 32'h99, 0, 1'b0);

    nextCycle();
    checkVal("sb_empty", 64'(hostQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
